source_read_n_k: RTL
====================

Name: source_read_n_k

Overview:
- Read-side counterpart of the source RAM packer.
- Fetches one stored 944-byte raw frame, held as 59 x 128-bit words in one of 4 source RAM banks, and unpacks it into a byte stream with a valid/ready handshake.
- Sits between the source RAM banks and the downstream encoder/transmit path.
- Byte order matches the packer: the first byte written is in bits [127:120] of each word.

Parameters:
- DATA_W, 128, RAM word width (must equal 16 x 8).
- ADDR_W, 8, RAM address width per bank.
- WORDS_PER_FRAME, 59, 128-bit words per frame (944 bytes).
- FRAME_STRIDE, 64, address spacing between frame slots inside one bank.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to read a frame; sampled only in IDLE.
- frame_sel  input  4  frame index 0..15; bank = frame_sel[3:2], slot = frame_sel[1:0].
- ram_rd_en  output  1  RAM read strobe.
- ram_sel  output  2  selected bank.
- ram_addr  output  ADDR_W  read address.
- ram_rd_data  input  DATA_W  read data; valid exactly 1 cycle after ram_rd_en.
- data_out  output  8  byte out.
- data_valid  output  1  data_out valid.
- data_ready  input  1  downstream accepts the byte.
- last_byte  output  1  high with the 944th byte.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset (async, any state):
  - All outputs 0: ram_rd_en, ram_sel, ram_addr, data_out, data_valid, last_byte, busy, done.
  - FSM to IDLE; word counter, byte index and buffer-valid flags cleared.
  - Reset mid-frame abandons the frame; no done pulse is generated.
- Address generation:
  - frame_sel is latched at start.
  - ram_sel = frame_sel[3:2].
  - ram_addr = frame_sel[1:0]*FRAME_STRIDE + word_idx, with word_idx 0..58. The result never exceeds 250, so there is no wrap.
- FSM states: IDLE, FETCH, STREAM, DONE.
  - IDLE: start=1 at edge T -> latch frame_sel, busy=1, go to FETCH.
  - FETCH: ram_rd_en=1 with word 0 address in cycle T+1. Data is captured into word buffer A at the end of T+2. Go to STREAM.
  - STREAM, byte output:
    - Bytes leave from A, MSB byte first (byte k = A[127-8k -: 8]).
    - data_valid is first high in cycle T+3.
    - A handshake is data_valid & data_ready; each handshake advances the byte index.
  - STREAM, prefetch:
    - Prefetch buffer B holds the next word.
    - A read is issued whenever B is empty, no read is in flight, and words remain.
    - When A's 16th byte is accepted and B is full, B moves to A in the same cycle. There is no bubble while data_ready=1.
    - If B is not yet filled, data_valid drops until it is.
  - STREAM -> DONE on the handshake of byte 944; last_byte=1 during that byte only.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Handshake rules:
  - While data_valid=1 and data_ready=0, data_out, last_byte and data_valid hold stable.
  - data_valid never depends combinationally on data_ready.
- Throughput:
  - With data_ready held 1, the 944 bytes appear in consecutive cycles T+3..T+946.
  - done is high in T+947 and the block is IDLE in T+948.
  - Total reads = 59, each address issued exactly once, in ascending order.
- Boundary conditions:
  - start while busy: ignored.
  - start and reset asserted together: reset wins.
  - data_ready low on the last byte: last_byte and data_valid hold until accepted; done follows on the cycle after acceptance.
  - ram_rd_data is sampled only in the cycle after its own ram_rd_en; other values are ignored.

Test Plan:
- RAM model with bank b, address a, word containing bytes {b,a,0..13} MSB first; start with frame_sel=4'd0 and data_ready=1 -> 944 contiguous bytes; the first word's bytes are 00,00,00..0D; addresses 0..58 on bank 0; last_byte at byte 944; done at T+947.
- frame_sel=4'd15 -> ram_sel=3, addresses 192..250, 59 reads, correct byte order.
- data_ready random 50% -> byte sequence identical to the gap-free run; output stable during stalls; no duplicate or skipped RAM reads.
- start pulse re-issued mid-frame with a different frame_sel -> ignored; the original frame completes unchanged.
- rst asserted at byte 500 -> all outputs 0 immediately and no done; a new start with frame_sel=5 then streams a full 944 bytes from bank 1, addresses 64..122.
- data_ready=0 when the 944th byte is presented for 10 cycles -> last_byte and data_valid held for those 10 cycles; done exactly one cycle after acceptance.

Source files
------------

// File: rtl/source_read_n_k.sv
// rtl/source_read_n_k.sv - unpacks one stored 944-byte frame from a source RAM bank into a byte stream
//
// Purpose:
//   Reads one frame (WORDS_PER_FRAME x DATA_W-bit words) from one of four
//   source RAM banks and emits it MSB byte first over a valid/ready byte
//   interface. A one-word prefetch buffer lets words follow each other
//   without a gap while data_ready stays high.
//
// Ports:
//   sys_clk      system clock, rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle read request, sampled only while idle
//   frame_sel    frame index; [3:2] = bank, [1:0] = slot within bank
//   ram_rd_en    RAM read strobe
//   ram_sel      RAM bank select
//   ram_addr     RAM read address
//   ram_rd_data  RAM read data, valid the cycle after ram_rd_en
//   data_out     output byte
//   data_valid   data_out valid
//   data_ready   downstream accepts the byte
//   last_byte    marks the final byte of the frame
//   busy         frame in progress
//   done         one-cycle pulse after the final byte is accepted

module source_read_n_k #(
    parameter int DATA_W          = 128,
    parameter int ADDR_W          = 8,
    parameter int WORDS_PER_FRAME = 59,
    parameter int FRAME_STRIDE    = 64
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        frame_sel,
    output logic              ram_rd_en,
    output logic [1:0]        ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [7:0]        data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              last_byte,
    output logic              busy,
    output logic              done
);

    localparam int BYTES_PER_WORD = DATA_W / 8;
    localparam int BIDX_W         = $clog2(BYTES_PER_WORD);
    localparam int CNT_W          = $clog2(WORDS_PER_FRAME + 1);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

    state_t state;
    state_t state_next;

    logic [3:0]        sel_q;
    logic [CNT_W-1:0]  rd_cnt;      // words requested so far
    logic              rd_pend;     // a read was issued last cycle
    logic [DATA_W-1:0] a_word;      // word currently being streamed
    logic              a_valid;
    logic [DATA_W-1:0] b_word;      // prefetched next word
    logic              b_valid;
    logic [BIDX_W-1:0] byte_idx;    // byte position within a_word
    logic [CNT_W-1:0]  out_word;    // index of the word held in a_word

    logic              handshake;
    logic              a_last;
    logic              a_done;
    logic              frame_last;
    logic              rd_issue;
    logic [ADDR_W-1:0] slot_base;
    logic [DATA_W-1:0] a_shift;

    // Handshake is built from state and buffer flags directly so that
    // data_valid itself never sits on a path that depends on data_ready.
    assign handshake  = (state == STREAM) && a_valid && data_ready;
    assign a_last     = (byte_idx == BIDX_W'(BYTES_PER_WORD - 1));
    assign a_done     = handshake && a_last;
    assign frame_last = a_valid && a_last && (out_word == CNT_W'(WORDS_PER_FRAME - 1));
    assign rd_issue   = !b_valid && !rd_pend && (rd_cnt < CNT_W'(WORDS_PER_FRAME));
    assign slot_base  = ADDR_W'(sel_q[1:0]) * ADDR_W'(FRAME_STRIDE);
    assign a_shift    = a_word << {byte_idx, 3'b000};

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ram_rd_en  = 1'b0;
        ram_sel    = 2'd0;
        ram_addr   = '0;
        data_out   = 8'd0;
        data_valid = 1'b0;
        last_byte  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busy       = 1'b1;
                ram_rd_en  = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                busy       = 1'b1;
                ram_rd_en  = rd_issue;
                data_valid = a_valid;
                if (a_valid) begin
                    data_out  = a_shift[DATA_W-1 -: 8];
                    last_byte = frame_last;
                end
                if (handshake && frame_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (ram_rd_en) begin
            ram_sel  = sel_q[3:2];
            ram_addr = slot_base + ADDR_W'(rd_cnt);
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sel_q    <= 4'd0;
            rd_cnt   <= '0;
            rd_pend  <= 1'b0;
            a_word   <= '0;
            a_valid  <= 1'b0;
            b_word   <= '0;
            b_valid  <= 1'b0;
            byte_idx <= '0;
            out_word <= '0;
        end else begin
            rd_pend <= ram_rd_en;
            if (ram_rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
            end

            if (state == IDLE && start) begin
                sel_q    <= frame_sel;
                rd_cnt   <= '0;
                byte_idx <= '0;
                out_word <= '0;
                a_valid  <= 1'b0;
                b_valid  <= 1'b0;
            end

            if (handshake) begin
                byte_idx <= byte_idx + 1'b1;
                if (a_last) begin
                    out_word <= out_word + 1'b1;
                    if (b_valid) begin
                        a_word  <= b_word;
                        b_valid <= 1'b0;
                    end else begin
                        a_valid <= 1'b0;
                    end
                end
            end

            // Returning data goes straight to the streaming buffer when it is
            // empty (first word) or emptying this cycle with nothing prefetched;
            // otherwise it parks in the prefetch buffer.
            if (rd_pend) begin
                if (!a_valid || (a_done && !b_valid)) begin
                    a_word  <= ram_rd_data;
                    a_valid <= 1'b1;
                end else begin
                    b_word  <= ram_rd_data;
                    b_valid <= 1'b1;
                end
            end
        end
    end

endmodule
